otp_stream_cipher: RTL and testbench

OTP_STREAM_CIPHER -- requirements
Module: otp_stream_cipher

---
 rtl/otp_pkg.sv | 23 ++
 rtl/otp_lfsr.sv | 29 ++
 rtl/otp_stream_cipher.sv | 107 ++++++++++
 tb/tb_otp_stream_cipher.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// Shared definitions for the one-time-pad stream cipher.
//   otp_state_e  : pad state (IDLE = no valid pad, RUN, EXHAUSTED)
//   DEFAULT_POLY : default 32-bit Galois LFSR feedback mask
//   lfsr_step    : one Galois LFSR step. It works on a 64-bit container, so
//                  the word width is limited to 64 bits. Narrower callers
//                  zero-extend the inputs and truncate the result. The zero
//                  upper bits shift down harmlessly.
package otp_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        EXHAUSTED = 2'd2
    } otp_state_e;

    localparam logic [31:0] DEFAULT_POLY = 32'h80200003;

    function automatic logic [63:0] lfsr_step(input logic [63:0] cur,
                                              input logic [63:0] poly);
        return cur[0] ? ((cur >> 1) ^ poly) : (cur >> 1);
    endfunction

endpackage

// File: rtl/otp_lfsr.sv
// Galois LFSR keystream generator.
//   clk, reset : clock, synchronous active-high reset (clears state)
//   load, seed : load seed into the register. A zero seed clears the register.
//   step       : advance one LFSR step (ignored while load is high)
//   state      : current keystream word
module otp_lfsr
    import otp_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] POLY   = DATA_W'(DEFAULT_POLY)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              step,
    output logic [DATA_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (reset)
            state <= '0;
        else if (load)
            state <= seed;
        else if (step)
            state <= DATA_W'(lfsr_step(64'(state), 64'(POLY)));
    end

endmodule

// File: rtl/otp_stream_cipher.sv
// One-time-pad stream cipher: out_data = in_data XOR keystream word.
// Each seed yields MAX_WORDS keystream words. After that, the block refuses
// input until it is reseeded, so a pad is never reused. Encryption and
// decryption are the same operation.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   seed_load, seed_in      : load a new pad. A zero seed is rejected with a
//                             one-cycle seed_err pulse.
//   in_valid/in_ready/in_data    : input word handshake
//   out_valid/out_ready/out_data : output word handshake (registered, latency 1)
//   key_exhausted           : pad used up, waiting for a reseed
//   word_count              : words consumed from the current pad, present
//                             only when OTP_STREAM_CIPHER_COUNT_EN is defined
module otp_stream_cipher
    import otp_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] POLY      = DATA_W'(DEFAULT_POLY),
    parameter int                MAX_WORDS = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] seed_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              key_exhausted,
    output logic              seed_err
`ifdef OTP_STREAM_CIPHER_COUNT_EN
    ,
    output logic [$clog2(MAX_WORDS+1)-1:0] word_count
`endif
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    otp_state_e        state, state_nx;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] lfsr;
    logic              in_xfer, out_xfer, last_word, seed_zero;

    assign seed_zero = (seed_in == '0);

    // A reseed cycle never accepts input. A held output blocks new input
    // unless the output is being drained in the same cycle.
    assign in_ready  = (state == RUN) && !seed_load && (!out_valid || out_ready);
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign last_word = (count == CNT_W'(MAX_WORDS - 1));

    assign key_exhausted = (state == EXHAUSTED);

    otp_lfsr #(.DATA_W(DATA_W), .POLY(POLY)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (seed_load),
        .seed  (seed_in),
        .step  (in_xfer),
        .state (lfsr)
    );

    always_comb begin
        state_nx = state;
        if (seed_load)
            state_nx = seed_zero ? IDLE : RUN;
        else if (in_xfer && last_word)
            state_nx = EXHAUSTED;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            seed_err  <= 1'b0;
        end else begin
            seed_err <= seed_load && seed_zero;
            if (seed_load) begin
                // A new pad drops any word still waiting at the output.
                count     <= '0;
                out_valid <= 1'b0;
            end else if (in_xfer) begin
                count     <= count + CNT_W'(1);
                out_valid <= 1'b1;
                out_data  <= in_data ^ lfsr;
            end else if (out_xfer) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef OTP_STREAM_CIPHER_COUNT_EN
    assign word_count = count;
`endif

endmodule

// File: tb/tb_otp_stream_cipher.sv
module tb_otp_stream_cipher;
    localparam int          MW = 4;
    localparam logic [31:0] P  = 32'h80200003;
    localparam logic [31:0] PT = 32'h67616C6F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, seed_load = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [31:0] seed_in = '0, in_data = '0;
    logic        in_ready, out_valid, key_exhausted, seed_err;
    logic [31:0] out_data;

    logic        lb_seed_load = 1'b0, lb_in_valid = 1'b0;
    logic        enc_in_ready, enc_out_valid, dec_in_ready, dec_out_valid;
    logic        enc_kx, enc_se, dec_kx, dec_se;
    logic [31:0] enc_out_data, dec_out_data;

`ifdef OTP_STREAM_CIPHER_COUNT_EN
    logic [2:0] word_count;
    logic [4:0] enc_wc, dec_wc;
`endif

    otp_stream_cipher #(.MAX_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .key_exhausted(key_exhausted), .seed_err(seed_err)
`ifdef OTP_STREAM_CIPHER_COUNT_EN
        , .word_count(word_count)
`endif
    );

    otp_stream_cipher enc (
        .clk(clk), .reset(reset), .seed_load(lb_seed_load), .seed_in(32'h1),
        .in_valid(lb_in_valid), .in_ready(enc_in_ready), .in_data(PT),
        .out_valid(enc_out_valid), .out_ready(dec_in_ready), .out_data(enc_out_data),
        .key_exhausted(enc_kx), .seed_err(enc_se)
`ifdef OTP_STREAM_CIPHER_COUNT_EN
        , .word_count(enc_wc)
`endif
    );

    otp_stream_cipher dec (
        .clk(clk), .reset(reset), .seed_load(lb_seed_load), .seed_in(32'h1),
        .in_valid(enc_out_valid), .in_ready(dec_in_ready), .in_data(enc_out_data),
        .out_valid(dec_out_valid), .out_ready(1'b1), .out_data(dec_out_data),
        .key_exhausted(dec_kx), .seed_err(dec_se)
`ifdef OTP_STREAM_CIPHER_COUNT_EN
        , .word_count(dec_wc)
`endif
    );

    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];

    // Reference model: the current keystream word, the words left on the pad,
    // and whether a valid pad is loaded.
    logic [31:0] m_key = '0;
    int          m_left = 0;
    bit          m_seeded = 1'b0;

    function automatic logic [31:0] ks_next(input logic [31:0] k);
        return k[0] ? ((k >> 1) ^ P) : (k >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle from the falling edge. It also checks in_ready and
    // key_exhausted against the model, and updates the model and the
    // scoreboard for whatever the coming rising edge will do.
    task automatic cycle(input bit rs, input bit sl, input logic [31:0] sd,
                         input bit vld, input logic [31:0] d, input bit ordy,
                         output bit acc);
        bit exp_rdy;
        @(negedge clk);
        reset = rs; seed_load = sl; seed_in = sd;
        in_valid = vld; in_data = d; out_ready = ordy;
        #1;
        chk("key_exhausted", 32'(key_exhausted), 32'(m_seeded && m_left == 0));
        exp_rdy = m_seeded && m_left > 0 && !sl && (!out_valid || ordy);
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        acc = vld && in_ready && !rs;
        if (acc) begin
            exp_q.push_back(d ^ m_key);
            m_key  = ks_next(m_key);
            m_left = m_left - 1;
        end
        if (rs || sl) begin
            #2;  // after the monitor has taken any word delivered this cycle
            exp_q.delete();
            if (rs || sd == 0) begin
                m_seeded = 1'b0; m_left = 0; m_key = '0;
            end else begin
                m_seeded = 1'b1; m_left = MW; m_key = sd;
            end
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks that
    // a stalled output holds still.
    initial begin
        bit          prev_hold = 1'b0, prev_clr = 1'b0;
        logic [31:0] prev_data = '0;
        forever begin
            @(negedge clk);
            #2;
            if (prev_hold && !prev_clr) begin
                chk("hold_valid", 32'(out_valid), 32'h1);
                chk("hold_data", out_data, prev_data);
            end
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'h0);
                end else begin
                    chk("out_data", out_data, exp_q.pop_front());
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_clr  = seed_load || reset;
        end
    end

    initial begin
        bit          acc;
        logic [31:0] w5, r, held;
        int          n, sent, got;

        cycle(1, 0, 0, 0, 0, 0, acc);
        cycle(1, 0, 0, 0, 0, 0, acc);
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_seed_err", 32'(seed_err), 32'h0);

        // Known keystream from seed 1.
        cycle(0, 1, 32'h1, 0, 0, 1, acc);
        cycle(0, 0, 0, 1, PT, 1, acc);
        chk("galo_accept", 32'(acc), 32'h1);
        cycle(0, 0, 0, 1, 32'h0, 1, acc);
        chk("galo_valid", 32'(out_valid), 32'h1);
        chk("galo_cipher", out_data, 32'h67616C6E);
        cycle(0, 0, 0, 1, $urandom, 1, acc);
        chk("second_key", out_data, 32'h80200003);
        cycle(0, 0, 0, 1, $urandom, 1, acc);   // fourth and last word of the pad

        // Pad exhausted: the fifth word waits until a reseed.
        w5 = $urandom;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 0, 1, w5, 1, acc);
            chk("exh_block", 32'(acc), 32'h0);
        end
        chk("exh_flag", 32'(key_exhausted), 32'h1);
        cycle(0, 1, 32'hA5A5A5A5, 1, w5, 1, acc);
        chk("reseed_block", 32'(acc), 32'h0);
        n = 0;
        do begin
            cycle(0, 0, 0, 1, w5, 1, acc);
            n++;
        end while (!acc && n < 5);
        chk("w5_accept", 32'(acc), 32'h1);

        // Back-pressure: three stalled cycles, then back-to-back words.
        cycle(0, 0, 0, 1, $urandom, 1, acc);
        chk("w5_cipher", out_data, w5 ^ 32'hA5A5A5A5);
        r = $urandom;
        cycle(0, 0, 0, 1, r, 0, acc);
        held = out_data;
        for (int i = 0; i < 2; i++) begin
            cycle(0, 0, 0, 1, r, 0, acc);
            chk("bp_block", 32'(acc), 32'h0);
            chk("bp_data", out_data, held);
        end
        cycle(0, 0, 0, 1, r, 1, acc);
        chk("bp_release", 32'(acc), 32'h1);
        cycle(0, 0, 0, 0, 0, 1, acc);
        cycle(0, 0, 0, 0, 0, 1, acc);
        chk("bp_drain", 32'(exp_q.size()), 32'h0);

        // A zero seed is rejected.
        cycle(0, 1, 32'h0, 0, 0, 1, acc);
        cycle(0, 0, 0, 1, $urandom, 1, acc);
        chk("zero_seed_err", 32'(seed_err), 32'h1);
        cycle(0, 0, 0, 1, $urandom, 1, acc);
        chk("zero_seed_pulse", 32'(seed_err), 32'h0);

        // Randomised traffic with occasional reseeds, some of them zero.
        cycle(0, 1, $urandom | 32'h1, 0, 0, 1, acc);
        for (int i = 0; i < 300; i++) begin
            bit          sl;
            logic [31:0] sd;
            sl = ($urandom_range(0, 19) == 0);
            sd = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom | 32'h100);
            cycle(0, sl, sd, $urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 2) != 0, acc);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1, acc);
        chk("rand_drain", 32'(exp_q.size()), 32'h0);

        // Reset wins over seed_load and a pending output.
        cycle(0, 1, 32'h1234_5679, 0, 0, 1, acc);
        cycle(0, 0, 0, 1, $urandom, 0, acc);
        cycle(1, 1, 32'h1234_5679, 0, 0, 0, acc);
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        cycle(0, 0, 0, 0, 0, 1, acc);
        chk("rst2_out_valid", 32'(out_valid), 32'h0);
        chk("rst2_out_data", out_data, 32'h0);
        chk("rst2_seed_err", 32'(seed_err), 32'h0);
        chk("rst2_kx", 32'(key_exhausted), 32'h0);

        // Loopback: the decipher instance recovers the plaintext.
        @(negedge clk); lb_seed_load = 1'b1;
        @(negedge clk); lb_seed_load = 1'b0;
        sent = 0; got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lb_in_valid = (sent < 4);
            #1;
            if (lb_in_valid && enc_in_ready) sent++;
            if (dec_out_valid) begin
                chk("loopback_data", dec_out_data, PT);
                got++;
            end
        end
        lb_in_valid = 1'b0;
        chk("loopback_count", 32'(got), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
